rr_arbiter_param: RTL and testbench

- Parametrised N-requester round-robin arbiter; next generation of the 4-way fixed arbiter.
- Registered one-hot grant, plus a binary grant index and a valid flag.
- Optional bounded grant hold (burst) with forced rotation on timeout.
- Sits between N request sources and one shared resource (bus, memory port, FIFO write side).

---
 rtl/rr_arbiter_param.sv | 107 ++++++++++
 tb/tb_rr_arbiter_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_param.sv
// Parametrised N-way round-robin arbiter with registered one-hot grant and bounded grant hold.
// Define RR_ARB_MASK_EN to add the req_mask input (effective request = req & ~req_mask).
module rr_arbiter_param #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 1,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
`ifdef RR_ARB_MASK_EN
    input  logic [N-1:0]   req_mask,
`endif
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic [IDW-1:0] last;
    logic [7:0]     hold_cnt;

    logic [N-1:0]   ereq;
    logic [N-1:0]   cand;
    logic [N-1:0]   rot;
    logic           cur_req;
    logic           others;
    logic           win_found;
    logic [IDW-1:0] win;

    logic [N-1:0]   gnt_nxt;
    logic           valid_nxt;
    logic [IDW-1:0] id_nxt;
    logic [IDW-1:0] last_nxt;
    logic [7:0]     hold_nxt;

`ifdef RR_ARB_MASK_EN
    assign ereq = req & ~req_mask;
`else
    assign ereq = req;
`endif

    // gnt is one-hot (or zero when idle), so it doubles as the mask of the current owner.
    assign cur_req = |(ereq & gnt);
    assign others  = |(ereq & ~gnt);
    assign cand    = ereq & ~gnt;

    // Rotate the candidates so that bit 0 is requester last+1, then take the lowest set bit.
    always_comb begin
        int s;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        s         = 0;
        win       = '0;
        win_found = 1'b0;
        rot       = N'({cand, cand} >> (32'(last) + 32'd1));
        for (int j = 0; j < N; j++) begin
            if (!win_found && rot[j]) begin
                win_found = 1'b1;
                s         = int'(last) + 1 + j;
                if (s >= N) s = s - N;
                win       = IDW'(s);
            end
        end
    end

    always_comb begin
        gnt_nxt   = gnt;
        valid_nxt = gnt_valid;
        id_nxt    = gnt_id;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        if (cur_req && (!others || hold_cnt < HOLD_MAX)) begin
            // Owner keeps the grant; the counter saturates at MAX_HOLD.
            if (hold_cnt < HOLD_MAX) hold_nxt = hold_cnt + 8'd1;
        end else if (win_found) begin
            gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << win;
            valid_nxt = 1'b1;
            id_nxt    = win;
            last_nxt  = win;
            hold_nxt  = 8'd1;
        end else begin
            // Nobody else requesting: go idle, keeping last as the previous owner.
            gnt_nxt   = '0;
            valid_nxt = 1'b0;
            id_nxt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            last      <= IDW'(N - 1);
            hold_cnt  <= 8'd0;
        end else begin
            gnt       <= gnt_nxt;
            gnt_valid <= valid_nxt;
            gnt_id    <= id_nxt;
            last      <= last_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Scoreboard bench for rr_arbiter_param: three configurations (N4/H1, N4/H3, N5/H1) checked
// against a rule-level reference model; exercises req_mask when RR_ARB_MASK_EN is defined.
module tb_rr_arbiter_param;

    typedef struct packed {
        logic [2:0][31:0] g;
        logic [2:0]       v;
        logic [2:0][7:0]  id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req_a = '0, req_b = '0;
    logic [4:0] req_c = '0;
    logic [3:0] mask_a = '0, mask_b = '0;
    logic [4:0] mask_c = '0;
    logic [3:0] gnt_a, gnt_b;
    logic [4:0] gnt_c;
    logic       val_a, val_b, val_c;
    logic [1:0] id_a, id_b;
    logic [2:0] id_c;

    exp_t q[$];
    int compared   = 0;
    int mismatched = 0;

    int owner[3];
    int last[3];
    int hold[3];

    always #5 clk = ~clk;

    rr_arbiter_param #(.N(4), .MAX_HOLD(1)) dut_a (
        .clk(clk), .rst(rst), .req(req_a),
`ifdef RR_ARB_MASK_EN
        .req_mask(mask_a),
`endif
        .gnt(gnt_a), .gnt_valid(val_a), .gnt_id(id_a));

    rr_arbiter_param #(.N(4), .MAX_HOLD(3)) dut_b (
        .clk(clk), .rst(rst), .req(req_b),
`ifdef RR_ARB_MASK_EN
        .req_mask(mask_b),
`endif
        .gnt(gnt_b), .gnt_valid(val_b), .gnt_id(id_b));

    rr_arbiter_param #(.N(5), .MAX_HOLD(1)) dut_c (
        .clk(clk), .rst(rst), .req(req_c),
`ifdef RR_ARB_MASK_EN
        .req_mask(mask_c),
`endif
        .gnt(gnt_c), .gnt_valid(val_c), .gnt_id(id_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [31:0] v, input int i);
        return ((v >> i) & 32'd1) != 32'd0;
    endfunction

    // Reference: apply the arbitration rules directly to the owner index / last / hold count.
    function automatic void model_step(input int n, input int maxh, input logic [31:0] eff,
                                       inout int own, inout int lst, inout int hld);
        bit own_req;
        bit rivals;
        int winner;
        own_req = (own >= 0) && bit_of(eff, own);
        rivals  = 1'b0;
        for (int i = 0; i < n; i++)
            if (i != own && bit_of(eff, i)) rivals = 1'b1;
        if (own_req && (!rivals || hld < maxh)) begin
            if (hld < maxh) hld++;
            return;
        end
        winner = -1;
        for (int k = 1; k <= n; k++) begin
            int idx;
            idx = (lst + k) % n;
            if (winner < 0 && idx != own && bit_of(eff, idx)) winner = idx;
        end
        if (winner >= 0) begin
            own = winner;
            lst = winner;
            hld = 1;
        end else begin
            own = -1;
        end
    endfunction

    task automatic cycle(input logic rv, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [4:0] rc);
        exp_t e;
        logic [31:0] eff[3];
        int nn[3];
        int mh[3];
        int o, l, h;
        nn = '{4, 4, 5};
        mh = '{1, 3, 1};
        @(negedge clk);
        rst   = rv;
        req_a = ra;
        req_b = rb;
        req_c = rc;
`ifdef RR_ARB_MASK_EN
        eff[0] = {28'd0, ra & ~mask_a};
        eff[1] = {28'd0, rb & ~mask_b};
        eff[2] = {27'd0, rc & ~mask_c};
`else
        eff[0] = {28'd0, ra};
        eff[1] = {28'd0, rb};
        eff[2] = {27'd0, rc};
`endif
        for (int i = 0; i < 3; i++) begin
            if (!rv) begin
                owner[i] = -1;
                last[i]  = nn[i] - 1;
                hold[i]  = 0;
            end else begin
                o = owner[i];
                l = last[i];
                h = hold[i];
                model_step(nn[i], mh[i], eff[i], o, l, h);
                owner[i] = o;
                last[i]  = l;
                hold[i]  = h;
            end
            e.g[i]  = (owner[i] >= 0) ? (32'd1 << owner[i]) : 32'd0;
            e.v[i]  = (owner[i] >= 0);
            e.id[i] = (owner[i] >= 0) ? 8'(owner[i]) : 8'd0;
        end
        q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("a.gnt",   {28'd0, gnt_a}, e.g[0]);
                check("a.valid", {31'd0, val_a}, {31'd0, e.v[0]});
                check("a.id",    {30'd0, id_a},  {24'd0, e.id[0]});
                check("b.gnt",   {28'd0, gnt_b}, e.g[1]);
                check("b.valid", {31'd0, val_b}, {31'd0, e.v[1]});
                check("b.id",    {30'd0, id_b},  {24'd0, e.id[1]});
                check("c.gnt",   {27'd0, gnt_c}, e.g[2]);
                check("c.valid", {31'd0, val_c}, {31'd0, e.v[2]});
                check("c.id",    {29'd0, id_c},  {24'd0, e.id[2]});
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            owner[i] = -1;
            last[i]  = (i == 2) ? 4 : 3;
            hold[i]  = 0;
        end
        // Reset, then idle.
        repeat (2) cycle(1'b0, 4'b0000, 4'b0000, 5'b00000);
        repeat (5) cycle(1'b1, 4'b0000, 4'b0000, 5'b00000);
        // Full contention on a and c; two-way hold/timeout on b.
        repeat (9) cycle(1'b1, 4'b1111, 4'b0011, 5'b11111);
        // Lone requester held on b; wrap-around and release on a.
        repeat (2) cycle(1'b1, 4'b1000, 4'b0100, 5'b00001);
        repeat (2) cycle(1'b1, 4'b1001, 4'b0100, 5'b00001);
        repeat (2) cycle(1'b1, 4'b0000, 4'b0100, 5'b00000);
        repeat (2) cycle(1'b1, 4'b1000, 4'b0100, 5'b10000);
        repeat (2) cycle(1'b1, 4'b0100, 4'b0100, 5'b10000);
        // Reset while granted, then release into full contention.
        cycle(1'b0, 4'b0100, 4'b0100, 5'b00100);
        repeat (6) cycle(1'b1, 4'b1111, 4'b1111, 5'b11111);
`ifdef RR_ARB_MASK_EN
        cycle(1'b0, 4'b0000, 4'b0000, 5'b00000);
        mask_c = 5'b00010;
        repeat (6) cycle(1'b1, 4'b1111, 4'b1111, 5'b11111);
        mask_c = 5'b00000;
`endif
        // Randomised traffic with occasional resets.
        for (int t = 0; t < 400; t++) begin
            logic rv;
            rv = ($urandom_range(0, 59) != 0);
`ifdef RR_ARB_MASK_EN
            mask_a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            mask_b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            mask_c = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
`endif
            cycle(rv, 4'($urandom), 4'($urandom | $urandom), 5'($urandom));
        end
        // Let the monitor drain the last expectation, bounded.
        for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
